// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encodings for the UART transmit path
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int DEF_ACK_TIMEOUT = 8;
    localparam int DEF_GAP_CYCLES  = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_ACK   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        ACK   = ST_ACK,
        DONE  = ST_DONE,
        GAP   = ST_GAP
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - circular byte FIFO with wrap-bit pointers and overflow detect
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow_evt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    // Modular difference of the wrap-extended pointers spans 0..DEPTH exactly.
    assign count = wr_ptr - rd_ptr;

    // full is the pre-edge value, so a write while full drops even alongside a pop.
    assign do_wr        = wr_en && !full;
    assign do_rd        = rd_en && !empty;
    assign overflow_evt = wr_en && full;
    assign rd_data      = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !rst) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - queues host bytes and sequences them into uart_tx via start/busy
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              ack_err,
    input  logic              clr_err,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int TMR_W     = 16;
    localparam int ACK_LIMIT = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
    localparam int GAP_LIMIT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    tx_state_t         state, state_n;
    logic [TMR_W-1:0]  timer, timer_n;
    logic [DATA_W-1:0] tx_data_n;
    logic              tx_start_n;
    logic              ack_err_n;
    logic              overflow_n;
    logic              pop;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              overflow_evt;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk          (clk_50),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (pop),
        .rd_data      (fifo_rd_data),
        .full         (full),
        .empty        (fifo_empty),
        .count        (count),
        .overflow_evt (overflow_evt)
    );

    assign empty = fifo_empty;

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        tx_data_n  = tx_data;
        pop        = 1'b0;
        ack_err_n  = ack_err & ~clr_err;
        overflow_n = overflow_evt | (overflow & ~clr_err);
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_data_n = fifo_rd_data;
                    state_n   = START;
                end
            end
            START: begin
                timer_n = '0;
                state_n = ACK;
            end
            ACK: begin
                // A byte that never gets acknowledged is dropped, not retried.
                if (tx_busy) begin
                    state_n = DONE;
                end else if (timer >= TMR_W'(ACK_LIMIT)) begin
                    ack_err_n = 1'b1;
                    timer_n   = '0;
                    state_n   = GAP;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DONE: begin
                if (!tx_busy) begin
                    timer_n = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (timer >= TMR_W'(GAP_LIMIT)) state_n = IDLE;
                else                            timer_n = timer + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        tx_start_n = (state_n == START);
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            ack_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            tx_data  <= tx_data_n;
            tx_start <= tx_start_n;
            ack_err  <= ack_err_n;
            overflow <= overflow_n;
        end
    end

endmodule
